// File: rtl/native_operand_packer.sv
// Assembles LANES-wide weight/activation beats into N-element flat vectors and
// issues each one with a single-cycle o_start, double-buffered behind a hold input.
module native_operand_packer #(
  parameter int N            = 128,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACT_WIDTH    = 4,
  parameter int LANES        = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0] s_weights,
  input  logic [LANES*ACT_WIDTH-1:0]    s_acts,
  input  logic                          s_last,
  input  logic                          i_hold,
  output logic                          o_start,
  output logic [N*WEIGHT_WIDTH-1:0]     o_weights_flat,
  output logic [N*ACT_WIDTH-1:0]        o_acts_flat,
  output logic [15:0]                   o_vec_cnt,
  output logic                          o_err
);

  localparam int BEATS = N / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WB    = LANES * WEIGHT_WIDTH;
  localparam int AB    = LANES * ACT_WIDTH;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pending_q, pending_d;
  logic                      err_q, err_d;
  logic                      start_q;
  logic [15:0]               vec_cnt_q;
  logic [N*WEIGHT_WIDTH-1:0] asm_w_q, asm_w_d, pend_w_q, out_w_q;
  logic [N*ACT_WIDTH-1:0]    asm_a_q, asm_a_d, pend_a_q, out_a_q;
  logic                      is_final, accept, complete, frame_err, issue;

  always_comb begin
    is_final  = (cnt_q == LAST_CNT);
    s_ready   = !(pending_q && i_hold && is_final);
    accept    = s_valid && s_ready;
    complete  = accept && is_final && s_last;
    frame_err = accept && (is_final != s_last);
    issue     = pending_q && !i_hold;

    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = (is_final || s_last) ? '0 : cnt_q + 1'b1;
    end
    // A completion on the issue edge refills the slot the issue just emptied.
    pending_d = complete || (pending_q && !issue);
    err_d     = err_q || frame_err;
  end

  // asm_*_d includes the beat being accepted, so a completing beat lands in
  // the pending buffer on the same edge it arrives.
  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      assign asm_w_d[gi*WB +: WB] = (accept && cnt_q == CNT_W'(gi)) ? s_weights : asm_w_q[gi*WB +: WB];
      assign asm_a_d[gi*AB +: AB] = (accept && cnt_q == CNT_W'(gi)) ? s_acts    : asm_a_q[gi*AB +: AB];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      pending_q <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      vec_cnt_q <= '0;
      asm_w_q   <= '0;
      asm_a_q   <= '0;
      pend_w_q  <= '0;
      pend_a_q  <= '0;
      out_w_q   <= '0;
      out_a_q   <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      err_q     <= err_d;
      start_q   <= issue;
      asm_w_q   <= asm_w_d;
      asm_a_q   <= asm_a_d;
      if (complete) begin
        pend_w_q <= asm_w_d;
        pend_a_q <= asm_a_d;
      end
      if (issue) begin
        out_w_q   <= pend_w_q;
        out_a_q   <= pend_a_q;
        vec_cnt_q <= vec_cnt_q + 16'd1;
      end
    end
  end

  assign o_start        = start_q;
  assign o_weights_flat = out_w_q;
  assign o_acts_flat    = out_a_q;
  assign o_vec_cnt      = vec_cnt_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_native_operand_packer.sv
// Randomised self-checking bench: an element-level packing model is compared
// against every DUT output on each falling edge, plus directed literal checks.
module tb_native_operand_packer;

  localparam int N     = 128;
  localparam int WW    = 4;
  localparam int AW    = 4;
  localparam int L     = 8;
  localparam int BEATS = N / L;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [L*WW-1:0] s_weights = '0;
  logic [L*AW-1:0] s_acts = '0;
  logic            s_last = 1'b0;
  logic            i_hold = 1'b0;
  logic            o_start;
  logic [N*WW-1:0] o_weights_flat;
  logic [N*AW-1:0] o_acts_flat;
  logic [15:0]     o_vec_cnt;
  logic            o_err;

  native_operand_packer #(.N(N), .WEIGHT_WIDTH(WW), .ACT_WIDTH(AW), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_weights(s_weights), .s_acts(s_acts), .s_last(s_last), .i_hold(i_hold),
    .o_start(o_start), .o_weights_flat(o_weights_flat), .o_acts_flat(o_acts_flat),
    .o_vec_cnt(o_vec_cnt), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  // ---------------- behavioural model (element arrays) ----------------
  int            m_cnt, m_vcnt;
  bit            m_pend, m_start, m_err;
  logic [WW-1:0] m_w [N];
  logic [AW-1:0] m_a [N];
  logic [WW-1:0] p_w [N];
  logic [AW-1:0] p_a [N];
  logic [WW-1:0] q_w [N];
  logic [AW-1:0] q_a [N];

  task automatic model_reset();
    m_cnt = 0; m_vcnt = 0; m_pend = 0; m_start = 0; m_err = 0;
    for (int i = 0; i < N; i++) begin
      m_w[i] = '0; m_a[i] = '0; p_w[i] = '0; p_a[i] = '0; q_w[i] = '0; q_a[i] = '0;
    end
  endtask

  task automatic model_step();
    bit rdy, acc, iss, fin;
    rdy = !(m_pend && i_hold && m_cnt == BEATS - 1);
    acc = s_valid && rdy;
    iss = m_pend && !i_hold;
    m_start = iss;
    if (iss) begin
      q_w = p_w; q_a = p_a;
      m_vcnt = (m_vcnt + 1) % 65536;
      m_pend = 0;
    end
    if (acc) begin
      for (int l = 0; l < L; l++) begin
        m_w[m_cnt*L + l] = s_weights[l*WW +: WW];
        m_a[m_cnt*L + l] = s_acts[l*AW +: AW];
      end
      fin = (m_cnt == BEATS - 1);
      if (fin && s_last) begin
        p_w = m_w; p_a = m_a; m_pend = 1; m_cnt = 0;
      end else if (fin || s_last) begin
        m_err = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // ---------------- per-cycle comparison ----------------
  int cyc = 0;
  int start_cnt = 0;
  int last_start = -1;
  bit stream_phase = 0;

  initial begin : cmp
    logic [N*WW-1:0] ew;
    logic [N*AW-1:0] ea;
    forever begin
      @(negedge clk);
      cyc++;
      check("o_start", o_start, m_start);
      check("o_vec_cnt", o_vec_cnt, m_vcnt);
      check("o_err", o_err, m_err);
      check("s_ready", s_ready, !(m_pend && i_hold && m_cnt == BEATS - 1));
      for (int i = 0; i < N; i++) begin
        ew[i*WW +: WW] = q_w[i];
        ea[i*AW +: AW] = q_a[i];
      end
      checks++;
      if (o_weights_flat === ew && o_acts_flat === ea) passes++;
      else $display("FAIL flat_outputs: got w=%h a=%h required w=%h a=%h", o_weights_flat, o_acts_flat, ew, ea);
      if (!stream_phase) last_start = -1;
      if (o_start) begin
        start_cnt++;
        if (stream_phase && last_start >= 0) check("stream_start_gap", cyc - last_start, 16);
        last_start = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_mode = 0;

  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic send_beat(input logic [L*WW-1:0] w, input logic [L*AW-1:0] a, input logic last);
    int   n;
    logic ok;
    if (rand_mode && $urandom_range(0, 3) == 0) begin
      s_valid = 1'b0;
      sync();
    end
    s_valid = 1'b1; s_weights = w; s_acts = a; s_last = last;
    n = 0;
    do begin
      if (rand_mode) i_hold = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      ok = s_ready;
      sync();
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      checks++;
      $display("FAIL beat_accept_timeout: s_ready=%0b after %0d cycles, required 1", ok, n);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_vec_rand(input int nb, input int last_beat);
    for (int b = 0; b < nb; b++) send_beat($urandom, $urandom, b == last_beat);
  endtask

  task automatic do_reset();
    sync();
    rst_n = 1'b0; s_valid = 1'b0; i_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L*WW-1:0] w, bw;
    logic [L*AW-1:0] a, ba;
    int bad_w, bad_a, s0;
    logic [15:0] v0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_o_start", o_start, 0);
    check("reset_vec_cnt", o_vec_cnt, 0);
    check("reset_err", o_err, 0);
    check("reset_s_ready", s_ready, 1);
    check("reset_flats_zero", (o_weights_flat == '0) && (o_acts_flat == '0), 1);
    rst_n = 1'b1;

    // Single vector: weight element i = i%16, act = 15 - weight.
    for (int b = 0; b < BEATS; b++) begin
      for (int l = 0; l < L; l++) begin
        w[l*WW +: WW] = 4'((b*L + l) % 16);
        a[l*AW +: AW] = 4'(15 - (b*L + l) % 16);
      end
      send_beat(w, a, b == BEATS - 1);
    end
    @(negedge clk); check("single_start_edge1", o_start, 0);
    @(negedge clk); check("single_start_edge2", o_start, 1);
    bad_w = 0; bad_a = 0;
    for (int i = 0; i < N; i++) begin
      if (o_weights_flat[i*WW +: WW] != 4'(i % 16)) bad_w++;
      if (o_acts_flat[i*AW +: AW] != 4'(15 - i % 16)) bad_a++;
    end
    check("single_bad_weights", bad_w, 0);
    check("single_bad_acts", bad_a, 0);
    check("single_vec_cnt", o_vec_cnt, 1);
    check("single_err", o_err, 0);
    @(negedge clk); check("single_start_pulse_end", o_start, 0);

    // Streaming: back-to-back vectors, no hold.
    do_reset();
    stream_phase = 1;
    s0 = start_cnt;
    repeat (1024) send_vec_rand(BEATS, BEATS - 1);
    repeat (4) @(negedge clk);
    stream_phase = 0;
    check("stream_starts", start_cnt - s0, 1024);
    check("stream_vec_cnt", o_vec_cnt, 1024);

    // Hold backpressure: A complete, B up to its final beat while held.
    sync();
    v0 = o_vec_cnt;
    i_hold = 1'b1;
    send_vec_rand(BEATS, BEATS - 1);
    send_vec_rand(BEATS - 1, -1);
    bw = $urandom; ba = $urandom;
    s_valid = 1'b1; s_weights = bw; s_acts = ba; s_last = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_s_ready_low", s_ready, 0);
      check("hold_no_start", o_start, 0);
    end
    sync();
    i_hold = 1'b0;
    send_beat(bw, ba, 1'b1);
    repeat (4) @(negedge clk);
    check("hold_vec_cnt", o_vec_cnt, 32'(v0) + 2);
    check("hold_err", o_err, 0);

    // Random hold and idle gaps.
    rand_mode = 1;
    repeat (50) send_vec_rand(BEATS, BEATS - 1);
    rand_mode = 0;
    i_hold = 1'b0;
    repeat (4) @(negedge clk);

    // Early s_last on beat 5, then a good vector.
    do_reset();
    s0 = start_cnt;
    send_vec_rand(6, 5);
    repeat (4) @(negedge clk);
    check("early_last_err", o_err, 1);
    check("early_last_no_start", start_cnt - s0, 0);
    sync();
    send_vec_rand(BEATS, BEATS - 1);
    repeat (4) @(negedge clk);
    check("early_last_recover_cnt", o_vec_cnt, 1);
    check("early_last_err_sticky", o_err, 1);

    // Reset mid-vector.
    sync();
    send_vec_rand(7, -1);
    rst_n = 1'b0;
    #1;
    check("midrst_start", o_start, 0);
    check("midrst_vec_cnt", o_vec_cnt, 0);
    check("midrst_err", o_err, 0);
    check("midrst_flats_zero", (o_weights_flat == '0) && (o_acts_flat == '0), 1);
    check("midrst_s_ready", s_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s0 = start_cnt;
    send_vec_rand(BEATS, BEATS - 1);
    repeat (4) @(negedge clk);
    check("midrst_fresh_starts", start_cnt - s0, 1);
    check("midrst_fresh_cnt", o_vec_cnt, 1);

    // Missing s_last on the final beat.
    sync();
    v0 = o_vec_cnt;
    send_vec_rand(BEATS, -1);
    repeat (4) @(negedge clk);
    check("missing_last_err", o_err, 1);
    check("missing_last_cnt", o_vec_cnt, 32'(v0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/native_operand_packer.md
# native_operand_packer

Upstream feeder for the `native_synth` dot-product stage. It accepts weight/activation elements as a narrow valid/ready stream, LANES elements per beat, and assembles them into N-element flat vectors. It presents each completed vector on flat buses with a single-cycle `o_start` pulse, which is the exact input contract of `native_synth`. Double buffering lets the next vector assemble while the previous one waits. A hold input from the downstream scheduler can delay issue.

## Interface
- `N`, 128, elements per vector; must be a multiple of `LANES`.
- `WEIGHT_WIDTH`, 4, bits per weight element.
- `ACT_WIDTH`, 4, bits per activation element.
- `LANES`, 8, elements per input beat; BEATS = N/LANES (16 at defaults).
- `clk  in  1  sole clock; all state updates on its rising edge.`
- `rst_n  in  1  asynchronous, active-low reset.`
- `s_valid  in  1  input beat valid.`
- `s_ready  out  1  packer can accept a beat (combinational).`
- `s_weights  in  LANES*WEIGHT_WIDTH  lane l at [l*WEIGHT_WIDTH +: WEIGHT_WIDTH].`
- `s_acts  in  LANES*ACT_WIDTH  lane l at [l*ACT_WIDTH +: ACT_WIDTH].`
- `s_last  in  1  marks the final beat of a vector.`
- `i_hold  in  1  downstream requests no issue this cycle.`
- `o_start  out  1  one-cycle pulse: flat buses carry a new vector.`
- `o_weights_flat  out  N*WEIGHT_WIDTH  assembled weights.`
- `o_acts_flat  out  N*ACT_WIDTH  assembled activations.`
- `o_vec_cnt  out  16  vectors issued, wraps modulo 2^16.`
- `o_err  out  1  sticky framing error.`

## Operation
- **Beat acceptance:** a beat is accepted on a rising edge where `s_valid && s_ready`.
- **Beat placement:** beat index `cnt` runs 0..BEATS-1. Lane l of beat `cnt` is element `cnt*LANES+l`. It is written into the assembly buffer at `[(cnt*LANES+l)*W +: W]`.
- **Vector completion:** an accepted beat with `cnt==BEATS-1` and `s_last=1` completes the vector.
  - The full assembly buffer, including that beat, is copied to the pending buffer.
  - `pending` is set to 1 and `cnt` returns to 0.
- **Framing error:** either of these is an error:
  - accepted beat with `s_last=1` and `cnt!=BEATS-1`;
  - accepted beat with `cnt==BEATS-1` and `s_last=0`.
- **On framing error:**
  - `o_err` is set and stays set until reset.
  - `cnt` returns to 0 and the partial vector is discarded.
  - `pending` is unchanged.
- **Issue:** on an edge where `pending && !i_hold`:
  - `o_weights_flat` and `o_acts_flat` are loaded from the pending buffer;
  - `o_start` is registered to 1 for exactly one cycle;
  - `o_vec_cnt` increments;
  - `pending` clears, unless a new vector completes on the same edge, in which case `pending` stays 1 with the new contents.
- **Ready:** `s_ready = !(pending && i_hold && cnt==BEATS-1)`.
  - Non-final beats are always accepted.
  - The final beat stalls only while the pending slot is full and blocked.
- **Held outputs:** flat outputs keep their last issued value until the next issue. `o_start` is 0 on every cycle without an issue.

## Timing
- **Reset:** while `rst_n=0`, and immediately upon assertion:
  - `o_start=0`, `o_weights_flat=0`, `o_acts_flat=0`, `o_vec_cnt=0`, `o_err=0`;
  - `cnt=0`, `pending=0`, assembly buffer cleared;
  - `s_ready=1`.
- **Mid-vector reset:** reset during a partial vector discards it. The first beat after release is element block 0.
- **Latency:** final beat accepted at edge E, `i_hold=0` → `pending=1` after E → `o_start=1` with valid buses during the cycle after E+1. This is 2 edges.
- **Throughput:** one vector per BEATS cycles with back-to-back beats and `i_hold=0`; no bubbles are inserted.
- **Hold:** `i_hold` is sampled each edge. A pending vector issues on the first edge with `i_hold=0`.
- **Simultaneous completion and issue:** the old pending vector goes to the outputs and the new one becomes pending; no data is lost.
- **Counter wrap:** `o_vec_cnt` goes 0xFFFF → 0x0000 with no flag.

## Test plan
- **Single vector:** reset, then 16 back-to-back beats with weight lane value = element index mod 16, acts = 15 - that value, `s_last` on beat 15, `i_hold=0`.
  - Exactly one `o_start` pulse, 2 edges after beat 15.
  - `o_weights_flat[i*4+:4] = i%16`.
  - `o_vec_cnt=1`, `o_err=0`.
- **Streaming:** 1024 vectors back-to-back, compared element-wise against a packing model.
  - 1024 `o_start` pulses, exactly 16 cycles apart.
  - `o_vec_cnt=1024`.
- **Hold backpressure:** hold `i_hold=1` while sending vector A fully and vector B's first 15 beats.
  - `s_ready` drops at B's beat 15 and `o_start` stays 0.
  - After `i_hold` goes 0: A issues, B's final beat is accepted, and B issues 2 edges later. Both are intact.
- **Early `s_last` on beat 5:** `o_err=1` and no `o_start`. The next 16-beat well-framed vector issues correctly and `o_err` stays 1.
- **Missing `s_last` on beat 15:** `o_err=1` and the vector is dropped; `o_vec_cnt` is unchanged.
- **Reset mid-vector:** assert `rst_n=0` after 7 beats.
  - All outputs are 0 immediately.
  - After release, a fresh 16-beat vector issues once with correct contents.
